// File: rtl/sm_pkg.sv
// Shared types and op-codes for the serial sign-magnitude add/sub unit.
package sm_pkg;

    typedef enum logic [2:0] {IDLE, CONV, ADD, NORM, DONE} sm_state_e;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

endpackage

// File: rtl/sm_tc_conv.sv
// Combinational sign-magnitude <-> two's-complement converter.
// TO_TC=1: SM (IN_W) -> sign-extended TC (OUT_W); TO_TC=0: TC (IN_W) -> SM (OUT_W).
module sm_tc_conv #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 5,
    parameter bit TO_TC = 1'b1
) (
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] q
);

    generate
        if (TO_TC) begin : g_to_tc
            logic [OUT_W-1:0] mag;
            assign mag = OUT_W'(d[IN_W-2:0]);
            // Negating a zero magnitude yields zero, so negative zero folds to +0.
            assign q   = d[IN_W-1] ? -mag : mag;
        end else begin : g_to_sm
            logic            neg;
            logic [IN_W-1:0] mag;
            assign neg = d[IN_W-1];
            assign mag = neg ? -d : d;
            assign q   = {neg, (OUT_W-1)'(mag)};
        end
    endgenerate

endmodule

// File: rtl/sm_addsub_serial.sv
// Bit-serial sign-magnitude adder/subtractor with a saturating accumulator.
// One request at a time: IDLE -> CONV -> ADD (WIDTH+2 bits) -> NORM -> DONE.
module sm_addsub_serial
    import sm_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic [1:0]       i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_res,
    output logic             o_z,
    output logic             o_ovf
);

    localparam int TW = WIDTH + 2;
    localparam int CW = $clog2(TW);

    sm_state_e state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH:0]   acc;
    logic [TW-1:0]    sh_a, sh_b, sum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             use_acc, is_sub, last_bit;
    logic             sum_bit, carry_nxt;
    logic [WIDTH:0]   sm_a;
    logic [TW-1:0]    tc_a, tc_b, res_sm;
    logic             res_sign;
    logic [WIDTH:0]   res_mag, res_next;

    assign use_acc  = (op_q == OP_ACC_ADD) || (op_q == OP_ACC_SUB);
    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_ACC_SUB);
    // Widen A to the accumulator's SM format so one converter serves both sources.
    assign sm_a     = use_acc ? acc : {a_q[WIDTH-1], 1'b0, a_q[WIDTH-2:0]};
    assign last_bit = (cnt == CW'(TW - 1));

    sm_tc_conv #(.IN_W(WIDTH + 1), .OUT_W(TW), .TO_TC(1'b1)) u_conv_a (
        .d (sm_a),
        .q (tc_a)
    );

    sm_tc_conv #(.IN_W(WIDTH), .OUT_W(TW), .TO_TC(1'b1)) u_conv_b (
        .d (b_q),
        .q (tc_b)
    );

    sm_tc_conv #(.IN_W(TW), .OUT_W(TW), .TO_TC(1'b0)) u_conv_res (
        .d (sum),
        .q (res_sm)
    );

    assign sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_nxt = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));

    // TC zero converts with a clear sign bit, so a zero sum is already all-zeros.
    assign res_sign  = res_sm[TW-1];
    assign res_mag   = res_sm[TW-2:0];
    assign res_next  = res_mag[WIDTH] ? {res_sign, {WIDTH{1'b1}}}
                                      : {res_sign, res_mag[WIDTH-1:0]};

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = CONV;
            CONV:    state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            acc   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            o_res <= '0;
            o_z   <= 1'b0;
            o_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q  <= i_A;
                        b_q  <= i_B;
                        op_q <= i_op;
                    end
                end
                CONV: begin
                    sh_a  <= tc_a;
                    sh_b  <= is_sub ? ~tc_b : tc_b;
                    carry <= is_sub;
                    cnt   <= '0;
                end
                ADD: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sum   <= {sum_bit, sum[TW-1:1]};
                    carry <= carry_nxt;
                    cnt   <= last_bit ? '0 : cnt + CW'(1);
                end
                NORM: begin
                    o_res <= res_next;
                    o_z   <= (res_mag == '0);
                    o_ovf <= res_mag[WIDTH];
                    acc   <= res_next;
                end
                default: ;
            endcase
        end
    end

endmodule
